// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtag_pkg
// Purpose  : IEEE 1149.1 TAP state codes and the per-state control decode.
// Revision : 1.0 - initial release
// ============================================================================
package jtag_pkg;

  localparam int TAP_STATE_W = 4;

  typedef enum logic [TAP_STATE_W-1:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PAU_DR = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PAU_IR = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_state_e;

  typedef struct packed {
    logic enable;
    logic shift;
    logic mode_shift_load;
    logic update;
    logic tdo_en;
    logic test_reset;
  } tap_ctrl_t;

  // Moore decode: every control bit is a pure function of the TAP state.
  function automatic tap_ctrl_t tap_decode(input tap_state_e s);
    tap_ctrl_t c;
    c.enable          = 1'b1;
    c.shift           = 1'b0;
    c.mode_shift_load = 1'b0;
    c.update          = 1'b0;
    c.tdo_en          = 1'b0;
    c.test_reset      = 1'b0;
    case (s)
      TLR:    c.test_reset = 1'b1;
      CAP_DR: c.shift = 1'b1;
      SH_DR: begin
        c.shift           = 1'b1;
        c.mode_shift_load = 1'b1;
        c.tdo_en          = 1'b1;
      end
      UPD_DR: c.update = 1'b1;
      SEL_IR: c.enable = 1'b0;
      CAP_IR: begin
        c.enable = 1'b0;
        c.shift  = 1'b1;
      end
      SH_IR: begin
        c.enable          = 1'b0;
        c.shift           = 1'b1;
        c.mode_shift_load = 1'b1;
        c.tdo_en          = 1'b1;
      end
      EX1_IR, PAU_IR, EX2_IR: c.enable = 1'b0;
      UPD_IR: begin
        c.enable = 1'b0;
        c.update = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage : jtag_pkg
`default_nettype wire

// File: rtl/tap_controller.sv
`default_nettype none
// ============================================================================
// Module   : tap_controller
// Purpose  : 16-state IEEE 1149.1 TAP controller with registered control outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tap_controller
  import jtag_pkg::*;
(
  input  logic                   TCK,
  input  logic                   RESET,
  input  logic                   TMS,
  output logic [TAP_STATE_W-1:0] TAP_STATE,
  output logic                   ENABLE,
  output logic                   SHIFT,
  output logic                   MODE_SHIFT_LOAD,
  output logic                   UPDATE,
  output logic                   TDO_EN,
  output logic                   TEST_RESET
);

  tap_state_e state_q, state_d;
  tap_ctrl_t  ctrl_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:    state_d = TMS ? TLR    : RTI;
      RTI:    state_d = TMS ? SEL_DR : RTI;
      SEL_DR: state_d = TMS ? SEL_IR : CAP_DR;
      CAP_DR: state_d = TMS ? EX1_DR : SH_DR;
      SH_DR:  state_d = TMS ? EX1_DR : SH_DR;
      EX1_DR: state_d = TMS ? UPD_DR : PAU_DR;
      PAU_DR: state_d = TMS ? EX2_DR : PAU_DR;
      EX2_DR: state_d = TMS ? UPD_DR : SH_DR;
      UPD_DR: state_d = TMS ? SEL_DR : RTI;
      SEL_IR: state_d = TMS ? TLR    : CAP_IR;
      CAP_IR: state_d = TMS ? EX1_IR : SH_IR;
      SH_IR:  state_d = TMS ? EX1_IR : SH_IR;
      EX1_IR: state_d = TMS ? UPD_IR : PAU_IR;
      PAU_IR: state_d = TMS ? EX2_IR : PAU_IR;
      EX2_IR: state_d = TMS ? UPD_IR : SH_IR;
      UPD_IR: state_d = TMS ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it,
  // so they always match state_q without any path from TMS to a pin.
  always_ff @(posedge TCK) begin
    if (RESET) begin
      state_q <= TLR;
      ctrl_q  <= tap_decode(TLR);
    end else begin
      state_q <= state_d;
      ctrl_q  <= tap_decode(state_d);
    end
  end

  assign TAP_STATE       = state_q;
  assign ENABLE          = ctrl_q.enable;
  assign SHIFT           = ctrl_q.shift;
  assign MODE_SHIFT_LOAD = ctrl_q.mode_shift_load;
  assign UPDATE          = ctrl_q.update;
  assign TDO_EN          = ctrl_q.tdo_en;
  assign TEST_RESET      = ctrl_q.test_reset;

endmodule : tap_controller
`default_nettype wire

// File: tb/tb_tap_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_tap_controller
// Purpose  : Randomised and directed checks of tap_controller against a table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tap_controller;
  import jtag_pkg::*;

  logic       TCK = 1'b0;
  logic       RESET = 1'b1;
  logic       TMS = 1'b1;
  logic [3:0] TAP_STATE;
  logic       ENABLE, SHIFT, MODE_SHIFT_LOAD, UPDATE, TDO_EN, TEST_RESET;

  tap_controller dut (
    .TCK             (TCK),
    .RESET           (RESET),
    .TMS             (TMS),
    .TAP_STATE       (TAP_STATE),
    .ENABLE          (ENABLE),
    .SHIFT           (SHIFT),
    .MODE_SHIFT_LOAD (MODE_SHIFT_LOAD),
    .UPDATE          (UPDATE),
    .TDO_EN          (TDO_EN),
    .TEST_RESET      (TEST_RESET)
  );

  always #5 TCK = ~TCK;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] nxt0 [16];
  logic [3:0] nxt1 [16];
  logic [3:0] m_state = 4'hF;
  logic       prev_upd = 1'b0;

  logic [3:0] seq28_tms  = 4'b0010;          // bit i = TMS of step i
  logic [3:0] seq28_st [4] = '{4'hC, 4'h7, 4'h6, 4'h2};
  logic [7:0] seq29_tms  = 8'b01100110;
  logic [3:0] seq29_st [8] = '{4'hC, 4'h7, 4'h4, 4'hE, 4'hA, 4'h9, 4'hD, 4'hC};
  logic [5:0] seq30_tms  = 6'b010001;
  logic [3:0] seq30_st [6] = '{4'h1, 4'h3, 4'h3, 4'h3, 4'h0, 4'h2};
  logic       seq30_sh [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic arc(input logic [3:0] s, input logic [3:0] on0, input logic [3:0] on1);
    nxt0[s] = on0;
    nxt1[s] = on1;
  endtask

  task automatic check_outputs();
    check("state",  {4'h0, TAP_STATE}, {4'h0, m_state});
    check("enable", {7'h0, ENABLE},
          {7'h0, !(m_state inside {SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR})});
    check("shift",  {7'h0, SHIFT},  {7'h0, m_state inside {CAP_DR, SH_DR, CAP_IR, SH_IR}});
    check("msl",    {7'h0, MODE_SHIFT_LOAD}, {7'h0, m_state inside {SH_DR, SH_IR}});
    check("update", {7'h0, UPDATE}, {7'h0, m_state inside {UPD_DR, UPD_IR}});
    check("tdo_en", {7'h0, TDO_EN}, {7'h0, m_state inside {SH_DR, SH_IR}});
    check("test_reset", {7'h0, TEST_RESET}, {7'h0, m_state == 4'hF});
    check("upd_twice", {7'h0, prev_upd & UPDATE}, 8'h0);
    prev_upd = UPDATE;
  endtask

  task automatic step(input logic tms, input logic rst);
    TMS   = tms;
    RESET = rst;
    @(posedge TCK);
    #1;
    m_state = rst ? 4'hF : (tms ? nxt1[m_state] : nxt0[m_state]);
    check_outputs();
  endtask

  initial begin
    arc(TLR, RTI, TLR);       arc(RTI, RTI, SEL_DR);
    arc(SEL_DR, CAP_DR, SEL_IR); arc(SEL_IR, CAP_IR, TLR);
    arc(CAP_DR, SH_DR, EX1_DR); arc(SH_DR, SH_DR, EX1_DR);
    arc(EX1_DR, PAU_DR, UPD_DR); arc(PAU_DR, PAU_DR, EX2_DR);
    arc(EX2_DR, SH_DR, UPD_DR); arc(UPD_DR, RTI, SEL_DR);
    arc(CAP_IR, SH_IR, EX1_IR); arc(SH_IR, SH_IR, EX1_IR);
    arc(EX1_IR, PAU_IR, UPD_IR); arc(PAU_IR, PAU_IR, EX2_IR);
    arc(EX2_IR, SH_IR, UPD_IR); arc(UPD_IR, RTI, SEL_DR);

    // Reset state, with TMS=0 to show reset wins.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("rst_state", {4'h0, TAP_STATE}, 8'h0F);

    for (int i = 0; i < 4; i++) begin
      step(seq28_tms[i], 1'b0);
      check("seq28_state", {4'h0, TAP_STATE}, {4'h0, seq28_st[i]});
      check("seq28_enable", {7'h0, ENABLE}, 8'h1);
    end
    check("seq28_shift", {6'h0, SHIFT, MODE_SHIFT_LOAD}, 8'h3);

    for (int i = 0; i < 6; i++) begin
      step(seq30_tms[i], 1'b0);
      check("seq30_state", {4'h0, TAP_STATE}, {4'h0, seq30_st[i]});
      check("seq30_shift", {7'h0, SHIFT}, {7'h0, seq30_sh[i]});
    end

    step(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(seq29_tms[i], 1'b0);
      check("seq29_state",  {4'h0, TAP_STATE}, {4'h0, seq29_st[i]});
      check("seq29_enable", {7'h0, ENABLE}, {7'h0, !(i >= 2 && i <= 6)});
      check("seq29_update", {7'h0, UPDATE}, {7'h0, i == 6});
    end

    // Reset mid-shift in SH_IR.
    step(1'b1, 1'b1);
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    check("shir_reached", {4'h0, TAP_STATE}, 8'h0A);
    step(1'b0, 1'b1);
    check("shir_rst_state", {4'h0, TAP_STATE}, 8'h0F);
    check("shir_rst_outs", {5'h0, SHIFT, UPDATE, TDO_EN}, 8'h0);
    step(1'b0, 1'b0);
    check("rst_release", {4'h0, TAP_STATE}, 8'h0C);

    // Five TMS=1 samples from every state.
    for (int s = 0; s < 16; s++) begin
      int k;
      step(1'b1, 1'b1);
      k = 0;
      while (m_state != 4'(s) && k < 2000) begin
        step(1'($urandom_range(0, 1)), 1'b0);
        k++;
      end
      check("reach_state", {4'h0, TAP_STATE}, 8'(s));
      for (int j = 0; j < 5; j++) step(1'b1, 1'b0);
      check("tms5_state", {4'h0, TAP_STATE}, 8'h0F);
      check("tms5_trst",  {7'h0, TEST_RESET}, 8'h1);
    end

    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 299) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_tap_controller
`default_nettype wire

// File: doc/tap_controller.md
TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001: TCK  input  1  test clock; all state changes occur on its rising edge.
REQ-002: RESET  input  1  synchronous, active-high reset, sampled on the rising edge of TCK.
REQ-003: TMS  input  1  test mode select, sampled on the rising edge of TCK.
REQ-004: TAP_STATE  output  4  current state, using the IEEE 1149.1 encoding in REQ-008.
REQ-005: ENABLE  output  1  register select: 1 = data register column, 0 = instruction register column (drives the instruction register ENABLE input).
REQ-006: SHIFT  output  1  capture/shift clock-enable for the selected register chain.
REQ-007: MODE_SHIFT_LOAD, UPDATE, TDO_EN, TEST_RESET  output  1 each  shift/load mode, update strobe, TDO drive enable, test-logic reset flag.

Function
REQ-008: The block SHALL implement a 16-state Moore FSM with these 4-bit codes:
- TLR=F, RTI=C
- SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PAU_DR=3, EX2_DR=0, UPD_DR=5
- SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PAU_IR=B, EX2_IR=8, UPD_IR=D
REQ-009: Transitions SHALL be, in the form (TMS=0 / TMS=1):
- TLR: RTI/TLR
- RTI: RTI/SEL_DR
- SEL_DR: CAP_DR/SEL_IR
- SEL_IR: CAP_IR/TLR
- CAP_x: SH_x/EX1_x
- SH_x: SH_x/EX1_x
- EX1_x: PAU_x/UPD_x
- PAU_x: PAU_x/EX2_x
- EX2_x: SH_x/UPD_x
- UPD_x: RTI/SEL_DR
REQ-010: Five consecutive TMS=1 samples SHALL reach TLR from any state, without RESET.
REQ-011: All outputs SHALL be decoded from the state register only; there is no combinational path from TMS to any output.
REQ-012: ENABLE SHALL be 0 in SEL_IR and in the states CAP_IR through UPD_IR, and 1 in all other states.
REQ-013: SHIFT SHALL be 1 in CAP_DR, SH_DR, CAP_IR and SH_IR, and 0 otherwise.
REQ-014: MODE_SHIFT_LOAD SHALL be 1 in SH_DR and SH_IR (shift), and 0 otherwise (parallel load/capture).
REQ-015: UPDATE SHALL be 1 only in UPD_DR and UPD_IR, so each pass through an update state gives exactly one TCK cycle of UPDATE.
REQ-016: TDO_EN SHALL be 1 only in SH_DR and SH_IR.
REQ-017: TEST_RESET SHALL be 1 only in TLR.
REQ-018: Each PAU_x state SHALL hold SHIFT, UPDATE and MODE_SHIFT_LOAD at 0 for every cycle TMS stays 0.
REQ-019: An EX2_x to SH_x re-entry SHALL resume shifting without a new capture cycle (SHIFT=1, MODE_SHIFT_LOAD=1).

Reset
REQ-020: RESET=1 at a rising TCK edge SHALL force TLR and take priority over TMS.
REQ-021: Reset SHALL act from any state, including mid-shift.
REQ-022: Output values in reset/TLR SHALL be:
- TAP_STATE=F
- ENABLE=1
- TEST_RESET=1
- SHIFT=0, MODE_SHIFT_LOAD=0, UPDATE=0, TDO_EN=0
REQ-023: Release of RESET SHALL leave the FSM in TLR; the first TMS=0 sample after release moves it to RTI.

Structure
REQ-024: The 16 state codes and the 4-bit state width SHALL be defined once in a shared package (jtag_pkg), reused by the instruction decoder and the testbench.
REQ-025: The block SHALL be a single module: one state register, one next-state process, one output decode.
REQ-026: The block SHALL have no sub-modules.
REQ-027: The outputs SHALL connect directly to the instruction register's SHIFT, UPDATE, ENABLE and MODE_SHIFT_LOAD inputs.

Verification
REQ-028: Reset, then TMS 0,1,0,0 -> TAP_STATE C,7,6,2; SHIFT=1 from CAP_DR on; MODE_SHIFT_LOAD=1 and TDO_EN=1 in SH_DR; ENABLE=1 throughout.
REQ-029: From TLR, TMS 0,1,1,0,0,1,1,0 -> C,7,4,E,A,9,D,C; ENABLE=0 from SEL_IR through UPD_IR; UPDATE=1 for exactly the D cycle.
REQ-030: From SH_DR, TMS 1,0,0,0,1,0 -> 1,3,3,3,0,2; SHIFT=0 during PAU_DR; SHIFT=1 again on return to SH_DR.
REQ-031: In each of the 16 states, apply TMS=1 for five cycles -> TAP_STATE=F and TEST_RESET=1 after the fifth edge.
REQ-032: Assert RESET for one cycle while in SH_IR with TMS=0 -> next TAP_STATE=F; SHIFT, UPDATE and TDO_EN all 0 that cycle.
REQ-033: Apply random TMS for 10^4 cycles against a reference FSM model -> TAP_STATE matches every cycle, and UPDATE is never high for two consecutive cycles.
